// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer: pops one weight set, reloads the array, streams activation rows and
// writes each result row once the array pipeline latency has elapsed.
module tpu_tile_scheduler #(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned MATRIX_SIZE = 64,
  parameter int unsigned PIPE_LAT    = 2 * MATRIX_SIZE + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   feed_valid,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   done
);

  // RUN cycle index must reach PIPE_LAT + num_vec without overflowing.
  localparam int unsigned CW = $clog2(PIPE_LAT + (1 << ADDRESSSIZE) + 1);

  typedef enum logic [2:0] {StIdle, StWaitW, StWload, StWlatch, StRun, StDone} state_e;

  state_e                 state_q;
  logic [ADDRESSSIZE-1:0] n_q;
  logic [ADDRESSSIZE-1:0] src_q;
  logic [ADDRESSSIZE-1:0] dst_q;
  logic [CW-1:0]          t_q;

  logic [CW-1:0]          t_end;
  logic [ADDRESSSIZE-1:0] w_idx;
  logic                   feed_nxt;
  logic                   wr_nxt;
  logic                   last;

  // t_q is the RUN cycle index whose outputs are being registered this edge.
  assign t_end    = CW'(PIPE_LAT) + CW'(n_q);
  assign w_idx    = t_q[ADDRESSSIZE-1:0] - ADDRESSSIZE'(PIPE_LAT);
  assign feed_nxt = t_q < CW'(n_q);
  assign wr_nxt   = (t_q >= CW'(PIPE_LAT)) && (t_q < t_end);
  assign last     = t_q == t_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      n_q              <= '0;
      src_q            <= '0;
      dst_q            <= '0;
      t_q              <= '0;
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      ub_address       <= '0;
      feed_valid       <= 1'b0;
      res_write_enable <= 1'b0;
      res_address      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      feed_valid       <= 1'b0;
      res_write_enable <= 1'b0;
      done             <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_vec == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              n_q   <= num_vec;
              src_q <= src_base;
              dst_q <= dst_base;
              busy  <= 1'b1;
              if (!fifo_empty) begin
                state_q          <= StWload;
                fifo_read_enable <= 1'b1;
              end else begin
                state_q <= StWaitW;
              end
            end
          end
        end
        StWaitW: begin
          if (!fifo_empty) begin
            state_q          <= StWload;
            fifo_read_enable <= 1'b1;
          end
        end
        StWload: begin
          state_q <= StWlatch;
          we_rl   <= 1'b1;
        end
        StWlatch: begin
          // First RUN cycle: row 0 is fed; PIPE_LAT >= 1 so no write yet.
          state_q    <= StRun;
          feed_valid <= 1'b1;
          ub_address <= src_q;
          t_q        <= CW'(1);
        end
        StRun: begin
          if (last) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            feed_valid       <= feed_nxt;
            ub_address       <= src_q + t_q[ADDRESSSIZE-1:0];
            res_write_enable <= wr_nxt;
            res_address      <= dst_q + w_idx;
            t_q              <= t_q + CW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Scoreboard bench: stimulus pushes expected (cycle, address) events, a negedge monitor
// pops and compares whenever a DUT raises a strobe.
module tb_tpu_tile_scheduler;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start [2];
  logic [AW-1:0] num_vec, src_base, dst_base;
  logic          fifo_empty;

  logic          fre [2];
  logic          rl [2];
  logic [AW-1:0] ub [2];
  logic          fv [2];
  logic          rwe [2];
  logic [AW-1:0] ra [2];
  logic          busy [2];
  logic          done [2];

  always #5 clk = ~clk;

  tpu_tile_scheduler #(.ADDRESSSIZE(AW), .PIPE_LAT(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .num_vec(num_vec), .src_base(src_base),
    .dst_base(dst_base), .fifo_empty(fifo_empty), .fifo_read_enable(fre[0]), .we_rl(rl[0]),
    .ub_address(ub[0]), .feed_valid(fv[0]), .res_write_enable(rwe[0]), .res_address(ra[0]),
    .busy(busy[0]), .done(done[0])
  );

  tpu_tile_scheduler #(.ADDRESSSIZE(AW), .PIPE_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .num_vec(num_vec), .src_base(src_base),
    .dst_base(dst_base), .fifo_empty(fifo_empty), .fifo_read_enable(fre[1]), .we_rl(rl[1]),
    .ub_address(ub[1]), .feed_valid(fv[1]), .res_write_enable(rwe[1]), .res_address(ra[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    int d;
    int c;
    int a;
  } ev_t;

  ev_t q_fre[$];
  ev_t q_rl[$];
  ev_t q_feed[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input ev_t e, input int a);
    n_cmp++;
    if (e.d != d || e.c != cyc || e.a != a) begin
      n_fail++;
      $display("FAIL %s: got dut%0d cycle %0d addr %0d, required dut%0d cycle %0d addr %0d",
               nm, d, cyc, a, e.d, e.c, e.a);
    end
  endtask

  task automatic unexp(input string nm, input int d);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: dut%0d strobe at cycle %0d, required none", nm, d, cyc);
  endtask

  task automatic chk_val(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int pending();
    return q_fre.size() + q_rl.size() + q_feed.size() + q_wr.size() + q_done.size();
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (fre[d]) begin
          if (q_fre.size() == 0) unexp("fifo_read_enable", d);
          else chk("fifo_read_enable", d, q_fre.pop_front(), 0);
        end
        if (rl[d]) begin
          if (q_rl.size() == 0) unexp("we_rl", d);
          else chk("we_rl", d, q_rl.pop_front(), 0);
        end
        if (fv[d]) begin
          if (q_feed.size() == 0) unexp("feed", d);
          else chk("feed", d, q_feed.pop_front(), int'(ub[d]));
          chk_val("busy_during_feed", int'(busy[d]), 1);
        end
        if (rwe[d]) begin
          if (q_wr.size() == 0) unexp("write", d);
          else chk("write", d, q_wr.pop_front(), int'(ra[d]));
        end
        if (done[d]) begin
          if (q_done.size() == 0) unexp("done", d);
          else chk("done", d, q_done.pop_front(), 0);
          chk_val("busy_at_done", int'(busy[d]), 0);
        end
      end
    end
  end

  // e: cycles fifo_empty is held high from the start cycle; rp: cycle of an extra start pulse.
  task automatic run_tile(input int d, input int n, input int src, input int dst, input int pl,
                          input int e, input int rp);
    int c;
    int k;
    @(negedge clk);
    c = cyc;
    if (n == 0) begin
      q_done.push_back('{d, c + 1, 0});
    end else begin
      q_fre.push_back('{d, c + 1 + e, 0});
      q_rl.push_back('{d, c + 2 + e, 0});
      for (int i = 0; i < n; i++) begin
        q_feed.push_back('{d, c + 3 + e + i, (src + i) % 1024});
        q_wr.push_back('{d, c + 3 + e + pl + i, (dst + i) % 1024});
      end
      q_done.push_back('{d, c + 3 + e + pl + n, 0});
    end
    num_vec  = AW'(n);
    src_base = AW'(src);
    dst_base = AW'(dst);
    k = 0;
    while (k < 400 && (k < 2 || pending() > 0)) begin
      start[d]   = (k == 0) || (k == rp);
      fifo_empty = (k < e);
      @(negedge clk);
      k = cyc - c;
    end
    start[d]   = 1'b0;
    fifo_empty = 1'b0;
    if (pending() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d events outstanding, required 0", pending());
      q_fre.delete(); q_rl.delete(); q_feed.delete(); q_wr.delete(); q_done.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int c;
    start[0] = 1'b0;
    start[1] = 1'b0;
    num_vec = '0;
    src_base = '0;
    dst_base = '0;
    fifo_empty = 1'b0;
    #12;
    for (int d = 0; d < 2; d++)
      chk_val("reset_outputs", int'({fre[d], rl[d], fv[d], ub[d], rwe[d], ra[d], busy[d],
                                     done[d]}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_tile(0, 4, 8, 'h20, 10, 0, -1);      // basic tile
    run_tile(1, 6, 0, 100, 3, 0, -1);        // feed/write overlap
    run_tile(1, 3, 1022, 1022, 3, 5, -1);    // empty FIFO wait, address wrap
    run_tile(1, 0, 0, 0, 3, 0, -1);          // zero length
    run_tile(1, 6, 40, 200, 3, 0, 5);        // start re-pulsed during RUN

    // Reset at the second feed cycle of a tile on the PIPE_LAT=10 instance.
    @(negedge clk);
    c = cyc;
    q_fre.push_back('{0, c + 1, 0});
    q_rl.push_back('{0, c + 2, 0});
    q_feed.push_back('{0, c + 3, 8});
    q_feed.push_back('{0, c + 4, 9});
    num_vec = AW'(4);
    src_base = AW'(8);
    dst_base = AW'('h20);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_val("outputs_after_rst", int'({fre[0], rl[0], fv[0], ub[0], rwe[0], ra[0], busy[0],
                                       done[0]}), 0);
    chk_val("events_before_rst", pending(), 0);
    q_fre.delete(); q_rl.delete(); q_feed.delete(); q_wr.delete(); q_done.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_tile(0, 4, 8, 'h20, 10, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
